// File: rtl/adc_frame_capture.sv
// adc_frame_capture: drops ADC pipeline-latency samples after enable, then streams framed bursts with per-frame OTR qualification
module adc_frame_capture #(
   parameter int DW = 14,
   parameter int SETTLE = 4,
   parameter int SAMP_NUM = 200,
   parameter int OTR_LIMIT = 1,
   parameter int FMT = 1,
   localparam int CW = $clog2(SAMP_NUM + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          Enable,
   input  logic          OTR,
   input  logic [DW-1:0] DataIn,
   output logic [DW-1:0] DataOut,
   output logic          DataValid,
   output logic          FrameStart,
   output logic          FrameLast,
   output logic          OverFlow,
   output logic [CW-1:0] OtrCnt,
   output logic          Abort
);
   localparam int SW = $clog2(SETTLE + 2);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] set_q, set_d;
   logic [CW-1:0] idx_q, idx_d, cnt_q, cnt_d, otrcnt_q, otrcnt_d, cnt_nx;
   logic [DW-1:0] data_q, data_d;
   logic          valid_q, valid_d, start_q, start_d, last_q, last_d;
   logic          ovf_q, ovf_d, abort_q, abort_d;

   // next-state and output decode; the running OTR count restarts on sample 0
   always_comb begin
      state_d = state_q;
      set_d = set_q;
      idx_d = idx_q;
      cnt_d = cnt_q;
      data_d = data_q;
      valid_d = 1'b0;
      start_d = 1'b0;
      last_d = 1'b0;
      ovf_d = ovf_q;
      otrcnt_d = otrcnt_q;
      abort_d = 1'b0;
      cnt_nx = (idx_q == '0 ? '0 : cnt_q) + CW'(OTR);
      case (state_q)
         S_IDLE: begin
            if (Enable) begin
               state_d = (SETTLE == 0) ? S_CAPTURE : S_SETTLE;
               set_d = '0;
               idx_d = '0;
            end
         end
         S_SETTLE: begin
            if (!Enable) state_d = S_IDLE;
            else if (set_q == SW'(SETTLE - 1)) begin
               state_d = S_CAPTURE;
               idx_d = '0;
            end else set_d = set_q + SW'(1);
         end
         S_CAPTURE: begin
            if (!Enable) begin
               state_d = S_IDLE;
               abort_d = (idx_q != '0);
               idx_d = '0;
            end else begin
               data_d = (FMT != 0) ? {~DataIn[DW-1], DataIn[DW-2:0]} : DataIn;
               valid_d = 1'b1;
               start_d = (idx_q == '0);
               last_d = (idx_q == CW'(SAMP_NUM - 1));
               idx_d = last_d ? '0 : idx_q + CW'(1);
               cnt_d = cnt_nx;
               if (last_d) begin
                  otrcnt_d = cnt_nx;
                  ovf_d = (cnt_nx >= CW'(OTR_LIMIT));
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state and registered outputs, cleared asynchronously
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         set_q <= '0;
         idx_q <= '0;
         cnt_q <= '0;
         data_q <= '0;
         valid_q <= 1'b0;
         start_q <= 1'b0;
         last_q <= 1'b0;
         ovf_q <= 1'b0;
         otrcnt_q <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         set_q <= set_d;
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         data_q <= data_d;
         valid_q <= valid_d;
         start_q <= start_d;
         last_q <= last_d;
         ovf_q <= ovf_d;
         otrcnt_q <= otrcnt_d;
         abort_q <= abort_d;
      end
   end

   assign DataOut = data_q;
   assign DataValid = valid_q;
   assign FrameStart = start_q;
   assign FrameLast = last_q;
   assign OverFlow = ovf_q;
   assign OtrCnt = otrcnt_q;
   assign Abort = abort_q;
endmodule

// File: doc/adc_frame_capture.md
# adc_frame_capture

Parametrised ADC capture front end, successor to the single-channel AD9240 control block. It discards a programmable number of ADC pipeline-latency samples after enable and converts offset-binary data to two's complement when configured. It then delivers continuous framed sample bursts of SAMP_NUM words to the digital demodulator, with per-frame overflow qualification for the PGA loop. It sits between the ADC pins (DataIn/OTR) and the demodulation/PGA modules.

## Interface
- DW, 14: ADC data width.
- SETTLE, 4: samples discarded after Enable rises (ADC pipeline latency); 0 allowed.
- SAMP_NUM, 200: samples per frame; ≥ 2.
- OTR_LIMIT, 1: number of OTR-flagged samples in a frame that makes OverFlow set; ≥ 1.
- FMT, 1: 1 = offset binary in, two's complement out (MSB inverted); 0 = pass-through.
- CW, $clog2(SAMP_NUM+1): counter width (derived, not overridden).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- Enable  in  1  level; high = capture running.
- OTR  in  1  ADC out-of-range flag, aligned with DataIn.
- DataIn  in  DW  ADC sample.
- DataOut  out  DW  converted sample.
- DataValid  out  1  DataOut holds a frame sample this cycle.
- FrameStart  out  1  with DataValid on sample 0 of a frame.
- FrameLast  out  1  with DataValid on sample SAMP_NUM-1.
- OverFlow  out  1  result of the last completed frame.
- OtrCnt  out  CW  OTR count of the last completed frame, saturating at SAMP_NUM.
- Abort  out  1  one-cycle pulse when a frame is cut short by Enable falling.

## Operation
- States: IDLE, SETTLE, CAPTURE. Every output is registered.
- IDLE: DataValid, FrameStart, FrameLast and Abort are 0. DataOut, OverFlow and OtrCnt hold. If Enable=1, go to SETTLE with settle counter 0, or straight to CAPTURE if SETTLE=0.
- SETTLE: counter increments each edge. On the edge where counter = SETTLE-1, go to CAPTURE with sample index 0. Samples in this state are dropped.
- CAPTURE: each edge registers DataOut = FMT ? {~DataIn[DW-1], DataIn[DW-2:0]} : DataIn and sets DataValid=1.
  - FrameStart=(idx==0), FrameLast=(idx==SAMP_NUM-1).
  - idx increments and wraps to 0 after SAMP_NUM-1. Frames run back-to-back with no gap and no re-settle.
- OTR accounting: a running count increments on each captured sample with OTR=1; sample 0 restarts it.
  - On the FrameLast edge, OtrCnt gets the final count, including that sample.
  - On the same edge, OverFlow = (final count ≥ OTR_LIMIT).
- Enable low in SETTLE or CAPTURE: on the next edge go to IDLE and clear DataValid, FrameStart and FrameLast.
  - Abort pulses if the state was CAPTURE with idx ≠ 0; no pulse from SETTLE.
  - The partial frame's count is discarded. OverFlow and OtrCnt keep the previous completed-frame values.
- Re-enable always passes through SETTLE again, and the frame restarts at idx 0.

## Timing
- Reset values: DataOut=0, DataValid=0, FrameStart=0, FrameLast=0, OverFlow=0, OtrCnt=0, Abort=0, state IDLE, all counters 0.
- Reset asserted mid-frame clears everything immediately, without waiting for an edge. No Abort pulse is generated.
- Enable first sampled high at edge k:
  - First DataValid/FrameStart after edge k+SETTLE+1, carrying DataIn from that edge.
  - With SETTLE=0, the first DataValid follows edge k+1.
- Latency DataIn→DataOut: 1 cycle. Throughput: 1 sample per clock.
- OverFlow and OtrCnt update in the same cycle that FrameLast is high, and are stable until the next FrameLast.
- Enable falling, last sampled high at edge m: the sample from edge m is still valid. DataValid=0 after edge m+1.
- Enable falling on the FrameLast edge: the frame completes normally, with OverFlow updated and no Abort.

## Test plan
- Reset: RST high mid-CAPTURE → all outputs 0 asynchronously. After release, IDLE until Enable.
- Basic frame (SETTLE=4, SAMP_NUM=8, FMT=1): ramp DataIn from 0x2000, Enable at edge 10 → first DataValid after edge 15 with DataOut=0x0000+ (MSB-inverted ramp), FrameStart there, FrameLast 7 cycles later.
- Back-to-back frames: hold Enable for 3 frames → 24 consecutive DataValid cycles, FrameStart every 8th, no gaps, no extra settle.
- Overflow (OTR_LIMIT=2): frame 1 has OTR on 1 sample → OverFlow=0, OtrCnt=1. Frame 2 has OTR on samples 0 and 7 → OverFlow=1, OtrCnt=2 on its FrameLast.
- Abort: drop Enable at idx 3 → Abort pulse one cycle, DataValid low, OverFlow/OtrCnt unchanged. Re-enable → 4 settle cycles, then FrameStart.
- FMT=0, SETTLE=0: Enable at edge k → DataValid after k+1 with DataOut=DataIn unmodified (0x1FFF→0x1FFF).
